// File: rtl/qerv_rf_ram_arb.sv
// ============================================================================
// qerv_rf_ram_arb
// ----------------------------------------------------------------------------
// Purpose
//   Sits between a bit-serial core's register-file port and a simple
//   dual-port SRAM (one write port, one registered read port). Adds a
//   debug access channel that only uses RAM port cycles the core leaves
//   free. The core always has priority. Its signals reach the RAM
//   combinationally, so the core is never stalled and sees no extra latency.
//
//   The read and write ports are arbitrated independently:
//     - a debug read is issued on the first cycle with i_c_ren = 0
//     - a debug write is issued on the first cycle with i_c_wen = 0
//
//   The RAM read data is registered: it is valid the cycle after o_ren.
//   A debug write and a core read that hit the same address in the same
//   cycle return the old data to the core. There is no bypass path.
//
// Configuration macro
//   QERV_RF_CLEAR_EN : when defined, a clear sequencer is built in. After
//                      reset release it writes zero to every RAM word, in
//                      ascending order, one word per free write cycle.
//                      o_init_done stays low until the clear has finished.
//                      When undefined, there is no clear state or counter
//                      and o_init_done is tied high.
//
// Parameters
//   width : SRAM data width in bits
//   aw    : SRAM word-address width (depth 2**aw)
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_c_waddr/i_c_wdata/i_c_wen   core write port
//   i_c_raddr/i_c_ren             core read port
//   o_c_rdata                     core read data (equal to i_rdata)
//   i_d_req/i_d_we/i_d_addr/
//   i_d_wdata                     debug request; held until o_d_ack
//   o_d_ack                       one-cycle debug completion pulse
//   o_d_rdata                     last debug read data (held)
//   o_waddr/o_wdata/o_wen         RAM write port
//   o_raddr/o_ren                 RAM read port
//   i_rdata                       RAM read data, one cycle after o_ren
//   o_init_done                   RAM is usable by the core
//
// Debug FSM
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for i_d_req; latches the request fields on accept
//   RD_ISSUE | waiting for a cycle with i_c_ren = 0, then drives o_ren
//   RD_DATA  | RAM data is on i_rdata; captures it into o_d_rdata
//   WR_ISSUE | waiting for a cycle with i_c_wen = 0, then drives o_wen
//   ACK      | o_d_ack = 1 for one cycle; i_d_req is ignored here
//   CLEAR    | (QERV_RF_CLEAR_EN only) zero-fill sweep after reset
// ============================================================================
module qerv_rf_ram_arb #(
    parameter int width = 8,
    parameter int aw    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    // core side
    input  logic [aw-1:0]    i_c_waddr,
    input  logic [width-1:0] i_c_wdata,
    input  logic             i_c_wen,
    input  logic [aw-1:0]    i_c_raddr,
    input  logic             i_c_ren,
    output logic [width-1:0] o_c_rdata,
    // debug side
    input  logic             i_d_req,
    input  logic             i_d_we,
    input  logic [aw-1:0]    i_d_addr,
    input  logic [width-1:0] i_d_wdata,
    output logic             o_d_ack,
    output logic [width-1:0] o_d_rdata,
    // RAM side
    output logic [aw-1:0]    o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [aw-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [width-1:0] i_rdata,
    // status
    output logic             o_init_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_DATA  = 3'd2,
        S_WR_ISSUE = 3'd3,
        S_ACK      = 3'd4
`ifdef QERV_RF_CLEAR_EN
        ,
        S_CLEAR    = 3'd5
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_we;
    logic [aw-1:0]    r_addr;
    logic [width-1:0] r_wdata;
    logic [width-1:0] r_d_rdata;

    logic             w_latch;     // accept the request in IDLE
    logic             w_capture;   // load o_d_rdata from i_rdata
    logic             w_dbg_wr;    // debug write owns the RAM write port
    logic             w_dbg_rd;    // debug read owns the RAM read port

`ifdef QERV_RF_CLEAR_EN
    logic [aw-1:0]    r_clr_addr;
    logic             r_init_done;
    logic             w_clr_wr;    // clear sweep owns the RAM write port
    logic             w_clr_last;

    assign w_clr_last = (r_clr_addr == {aw{1'b1}});
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
`ifdef QERV_RF_CLEAR_EN
            r_state     <= S_CLEAR;
            r_clr_addr  <= '0;
            r_init_done <= 1'b0;
`else
            r_state     <= S_IDLE;
`endif
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_we    <= i_d_we;
                r_addr  <= i_d_addr;
                r_wdata <= i_d_wdata;
            end
            if (w_capture) begin
                r_d_rdata <= i_rdata;
            end
`ifdef QERV_RF_CLEAR_EN
            // The address advances only on cycles where a zero word was
            // actually written, so core write cycles just stretch the sweep.
            if (w_clr_wr) begin
                r_clr_addr <= r_clr_addr + 1'b1;
                if (w_clr_last) begin
                    r_init_done <= 1'b1;
                end
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next state and port grants
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        w_dbg_wr     = 1'b0;
        w_dbg_rd     = 1'b0;
`ifdef QERV_RF_CLEAR_EN
        w_clr_wr     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_d_req) begin
                    w_latch      = 1'b1;
                    w_state_next = i_d_we ? S_WR_ISSUE : S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                if (!i_c_ren) begin
                    w_dbg_rd     = ~r_we;
                    w_state_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                w_capture    = 1'b1;
                w_state_next = S_ACK;
            end
            S_WR_ISSUE: begin
                if (!i_c_wen) begin
                    w_dbg_wr     = r_we;
                    w_state_next = S_ACK;
                end
            end
            S_ACK: begin
                w_state_next = S_IDLE;
            end
`ifdef QERV_RF_CLEAR_EN
            S_CLEAR: begin
                // The state register resets into CLEAR. Gating with i_rst
                // keeps the sweep from writing while reset is still held.
                if (!i_c_wen && !i_rst) begin
                    w_clr_wr = 1'b1;
                    if (w_clr_last) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM port muxes: the core path is purely combinational
    // ------------------------------------------------------------------
`ifdef QERV_RF_CLEAR_EN
    assign o_wen       = i_c_wen | w_dbg_wr | w_clr_wr;
    assign o_waddr     = w_dbg_wr ? r_addr  :
                         w_clr_wr ? r_clr_addr : i_c_waddr;
    assign o_wdata     = w_dbg_wr ? r_wdata :
                         w_clr_wr ? {width{1'b0}} : i_c_wdata;
    assign o_init_done = r_init_done;
`else
    assign o_wen       = i_c_wen | w_dbg_wr;
    assign o_waddr     = w_dbg_wr ? r_addr  : i_c_waddr;
    assign o_wdata     = w_dbg_wr ? r_wdata : i_c_wdata;
    assign o_init_done = 1'b1;
`endif

    assign o_ren     = i_c_ren | w_dbg_rd;
    assign o_raddr   = w_dbg_rd ? r_addr : i_c_raddr;
    assign o_c_rdata = i_rdata;

    assign o_d_ack   = (r_state == S_ACK);
    assign o_d_rdata = r_d_rdata;

endmodule

// File: tb/tb_qerv_rf_ram_arb.sv
module tb_qerv_rf_ram_arb;
    localparam int W     = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef QERV_RF_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] c_waddr = '0, c_raddr = '0, d_addr = '0;
    logic [W-1:0]  c_wdata = '0, d_wdata = '0;
    logic          c_wen = 1'b0, c_ren = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [W-1:0]  o_c_rdata, o_d_rdata, o_wdata, i_rdata;
    logic [AW-1:0] o_waddr, o_raddr;
    logic          o_d_ack, o_wen, o_ren, o_init_done;

    qerv_rf_ram_arb #(.width(W), .aw(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_c_waddr(c_waddr), .i_c_wdata(c_wdata), .i_c_wen(c_wen),
        .i_c_raddr(c_raddr), .i_c_ren(c_ren), .o_c_rdata(o_c_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
        .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata),
        .o_init_done(o_init_done)
    );

    always #5 clk = ~clk;

    // Environment SRAM: registered read, read-before-write on the same edge.
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (o_ren) ram_q <= mem[o_raddr];
        if (o_wen) mem[o_waddr] <= o_wdata;
    end
    assign i_rdata = ram_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. It tracks RAM contents and the outstanding debug
    // transaction. It does not track arbiter states: the model only knows
    // that a pending op issues on the first free port cycle, and that the
    // ack follows 1 cycle (write) or 2 cycles (read) after the issue.
    // ------------------------------------------------------------------
    logic [W-1:0]  shadow [DEPTH];
    bit            m_pend = 0, m_we = 0, m_issued = 0;
    int            m_wait = 0;
    logic [AW-1:0] m_addr = '0;
    logic [W-1:0]  m_wdata = '0, m_rdata = '0, m_rd_hold = '0, m_cdata = '0;
    bit            m_cvalid = 0;
    bit            m_clearing = CLEAR_EN;
    int            m_clr = 0;

    function automatic bit f_dbg_wr();
        return m_pend && m_we && !m_issued && !c_wen;
    endfunction
    function automatic bit f_dbg_rd();
        return m_pend && !m_we && !m_issued && !c_ren;
    endfunction
    function automatic bit f_clr_wr();
        return m_clearing && !c_wen && !rst;
    endfunction
    function automatic bit f_ack();
        return m_pend && m_issued && (m_wait == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit dw, dr, cw, ak;
        if (rst) begin
            m_pend = 0; m_issued = 0; m_wait = 0; m_rdata = '0;
            m_cvalid = 0; m_clearing = CLEAR_EN; m_clr = 0;
        end else begin
            dw = f_dbg_wr(); dr = f_dbg_rd(); cw = f_clr_wr(); ak = f_ack();
            m_cvalid = c_ren;
            if (c_ren) m_cdata = shadow[c_raddr];
            if (dr) m_rd_hold = shadow[m_addr];
            if (c_wen) shadow[c_waddr] = c_wdata;
            else if (dw) shadow[m_addr] = m_wdata;
            else if (cw) shadow[m_clr] = '0;
            if (cw) begin
                if (m_clr == DEPTH - 1) m_clearing = 0;
                else m_clr++;
            end
            if (ak) m_pend = 0;
            else if (m_pend && m_issued && m_wait > 0) begin
                m_wait--;
                m_rdata = m_rd_hold;
            end else if (dw || dr) begin
                m_issued = 1;
                m_wait = dr ? 1 : 0;
            end else if (!m_pend && d_req && !m_clearing) begin
                m_pend = 1; m_issued = 0; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
            end
        end
    end

    // Per-cycle compare process, sampled mid-cycle
    always @(negedge clk) begin
        bit dw, dr, cw;
        if (rst) begin
            chk("ack_in_reset", o_d_ack, 0);
            chk("d_rdata_in_reset", o_d_rdata, 0);
        end else begin
            dw = f_dbg_wr(); dr = f_dbg_rd(); cw = f_clr_wr();
            chk("c_rdata_pass", o_c_rdata, i_rdata);
            if (m_cvalid) chk("core_read_data", i_rdata, m_cdata);
            chk("wen", o_wen, c_wen | dw | cw);
            if (c_wen) begin
                chk("waddr_core", o_waddr, c_waddr);
                chk("wdata_core", o_wdata, c_wdata);
            end else if (dw) begin
                chk("waddr_dbg", o_waddr, m_addr);
                chk("wdata_dbg", o_wdata, m_wdata);
            end else if (cw) begin
                chk("waddr_clr", o_waddr, m_clr);
                chk("wdata_clr", o_wdata, 0);
            end
            chk("ren", o_ren, c_ren | dr);
            if (c_ren) chk("raddr_core", o_raddr, c_raddr);
            else if (dr) chk("raddr_dbg", o_raddr, m_addr);
            chk("d_ack", o_d_ack, f_ack());
            chk("d_rdata", o_d_rdata, m_rdata);
            chk("init_done", o_init_done, !m_clearing);
        end
    end

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    // Waits for o_init_done, driving core writes for the first inj cycles.
    task automatic wait_init(input int inj, output int n);
        n = 0;
        while (!o_init_done && n < 4 * DEPTH) begin
            if (n < inj) begin
                c_wen = 1'b1; c_waddr = AW'(8'hF0 + n); c_wdata = W'(n + 1);
            end else c_wen = 1'b0;
            next_cyc();
            n++;
        end
        c_wen = 1'b0;
        chk("init_done_reached", o_init_done, 1);
    endtask

    initial begin
        int ncyc, gap, held;
        bit ack_seen;
        logic [W-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = W'($urandom);
            mem[i] = v;
            shadow[i] = v;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", o_d_ack, 0);
        chk("rst_d_rdata", o_d_rdata, 0);
        chk("rst_wen", o_wen, 0);
        next_cyc();
        rst = 1'b0;
`ifdef QERV_RF_CLEAR_EN
        chk("rst_init_done", o_init_done, 0);
        wait_init(0, ncyc);
        chk("clear_cycles", ncyc, DEPTH);
`else
        chk("rst_init_done", o_init_done, 1);
        wait_init(0, ncyc);
`endif

        // Debug write 0x12 <- 0xA5 with an idle core
        next_cyc(); d_req = 1; d_we = 1; d_addr = 8'h12; d_wdata = 8'hA5;
        next_cyc(); @(negedge clk);
        chk("wr_wen", o_wen, 1); chk("wr_waddr", o_waddr, 8'h12);
        chk("wr_wdata", o_wdata, 8'hA5); chk("wr_ack_early", o_d_ack, 0);
        next_cyc(); @(negedge clk);
        chk("wr_ack", o_d_ack, 1);
        next_cyc(); d_req = 0;

        // Debug read 0x12
        next_cyc(); d_req = 1; d_we = 0; d_addr = 8'h12;
        next_cyc(); @(negedge clk);
        chk("rd_ren", o_ren, 1); chk("rd_raddr", o_raddr, 8'h12); chk("rd_ack_early", o_d_ack, 0);
        next_cyc(); @(negedge clk);
        chk("rd_ack_early2", o_d_ack, 0);
        next_cyc(); @(negedge clk);
        chk("rd_ack", o_d_ack, 1); chk("rd_data", o_d_rdata, 8'hA5);
        next_cyc(); d_req = 0;

        // Debug read behind 10 core-read cycles
        next_cyc(); c_ren = 1; c_raddr = 8'h40; d_req = 1; d_we = 0; d_addr = 8'h12;
        for (int k = 1; k < 10; k++) begin
            next_cyc(); @(negedge clk);
            chk("core_raddr_hold", o_raddr, 8'h40);
            chk("blocked_ack", o_d_ack, 0);
        end
        next_cyc(); c_ren = 0; @(negedge clk);
        chk("deferred_ren", o_ren, 1); chk("deferred_raddr", o_raddr, 8'h12);
        next_cyc(); next_cyc(); @(negedge clk);
        chk("deferred_ack", o_d_ack, 1); chk("deferred_data", o_d_rdata, 8'hA5);
        next_cyc(); d_req = 0;

        // Debug write colliding with a one-cycle core write to 0x05
        next_cyc(); d_req = 1; d_we = 1; d_addr = 8'h05; d_wdata = 8'h3C;
        next_cyc(); c_wen = 1; c_waddr = 8'h05; c_wdata = 8'h77; @(negedge clk);
        chk("coll_core_wdata", o_wdata, 8'h77);
        next_cyc(); c_wen = 0; @(negedge clk);
        chk("coll_dbg_wen", o_wen, 1); chk("coll_dbg_wdata", o_wdata, 8'h3C);
        next_cyc(); @(negedge clk);
        chk("coll_ack", o_d_ack, 1);
        next_cyc(); d_req = 0; c_ren = 1; c_raddr = 8'h05;
        next_cyc(); c_ren = 0; @(negedge clk);
        chk("coll_final", o_c_rdata, 8'h3C);

        // Randomized traffic on a small address window to provoke collisions
        gap = 0; held = 0; ack_seen = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            next_cyc();
            c_wen = ($urandom_range(0, 99) < 35);
            c_waddr = AW'($urandom_range(0, 15)); c_wdata = W'($urandom);
            c_ren = ($urandom_range(0, 99) < 35);
            c_raddr = AW'($urandom_range(0, 15));
            if (d_req && ack_seen) begin
                d_req = 0; gap = $urandom_range(0, 3);
            end else if (!d_req) begin
                if (gap > 0) gap--;
                else begin
                    d_req = 1; d_we = 1'($urandom_range(0, 1));
                    d_addr = AW'($urandom_range(0, 15)); d_wdata = W'($urandom); held = 0;
                end
            end else begin
                held++;
                if (held > 600) begin
                    n_checks++; n_errors++;
                    $display("FAIL dbg_ack_timeout: no ack after %0d cycles", held);
                    d_req = 0;
                end
            end
            ack_seen = 0;
            @(negedge clk);
            if (o_d_ack) ack_seen = 1;
        end
        c_wen = 0; c_ren = 0;
        for (int k = 0; k < 50 && d_req && !ack_seen; k++) begin
            next_cyc(); @(negedge clk);
            if (o_d_ack) ack_seen = 1;
        end
        next_cyc(); d_req = 0;
        repeat (2) next_cyc();

        // Reset asserted while the read sits in its data cycle
        d_req = 1; d_we = 0; d_addr = 8'h12;
        next_cyc();
        next_cyc();
        rst = 1; d_req = 0;
        @(negedge clk);
        chk("midrst_ack", o_d_ack, 0); chk("midrst_rdata", o_d_rdata, 0); chk("midrst_wen", o_wen, 0);
        repeat (2) next_cyc();
        rst = 0;
`ifdef QERV_RF_CLEAR_EN
        wait_init(3, ncyc);
        chk("reclear_cycles", ncyc, DEPTH + 3);
`else
        wait_init(0, ncyc);
`endif
        for (int k = 0; k < 4; k++) begin
            next_cyc(); @(negedge clk);
            chk("postrst_ack", o_d_ack, 0);
        end
        chk("postrst_rdata", o_d_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/qerv_rf_ram_arb.md
QERV_RF_RAM_ARB -- requirements
Module: qerv_rf_ram_arb

Interface
REQ-001 SHALL have parameter width, default 8, meaning SRAM data width in bits.
REQ-002 SHALL have parameter aw, default 8, meaning SRAM word-address width (depth 2^aw).
REQ-003 SHALL have ports: i_clk input 1 clock; i_rst input 1 reset, asynchronous, active-high.
REQ-004 SHALL have core-side ports: i_c_waddr in aw; i_c_wdata in width; i_c_wen in 1; i_c_raddr in aw; i_c_ren in 1; o_c_rdata out width.
REQ-005 SHALL have debug-side ports: i_d_req in 1; i_d_we in 1; i_d_addr in aw; i_d_wdata in width; o_d_ack out 1; o_d_rdata out width.
REQ-006 SHALL have RAM-side ports: o_waddr out aw; o_wdata out width; o_wen out 1; o_raddr out aw; o_ren out 1; i_rdata in width (valid the cycle after o_ren).
REQ-007 SHALL have o_init_done out 1, high when the RAM is usable by the core.

Function
REQ-008 Core access SHALL always win; core signals pass combinationally to RAM ports with zero added latency, and the core is never stalled.
REQ-009 o_c_rdata SHALL equal i_rdata combinationally.
REQ-010 Read and write ports SHALL be arbitrated independently; a debug read uses only cycles with i_c_ren=0, a debug write only cycles with i_c_wen=0.
REQ-011 Debug FSM states: IDLE, RD_ISSUE, RD_DATA, WR_ISSUE, ACK.
REQ-012 IDLE: on i_d_req=1 latch i_d_we, i_d_addr, i_d_wdata; go to WR_ISSUE if we=1, else RD_ISSUE.
REQ-013 RD_ISSUE: when i_c_ren=0, drive o_ren=1, o_raddr=latched addr, go to RD_DATA; else remain.
REQ-014 RD_DATA: capture i_rdata into o_d_rdata register, go to ACK.
REQ-015 WR_ISSUE: when i_c_wen=0, drive o_wen=1, o_waddr/o_wdata=latched values, go to ACK; else remain.
REQ-016 ACK: o_d_ack=1 for exactly one cycle, go to IDLE; i_d_req is not sampled in ACK.
REQ-017 Best-case latency i_d_req to o_d_ack: write 2 cycles, read 3 cycles.
REQ-018 i_d_req SHALL be held by the requester until o_d_ack; request fields change only in IDLE.
REQ-019 o_d_rdata SHALL hold its value until the next debug read completes.
REQ-020 A debug write to address A and a core read of A in the same cycle SHALL return pre-write data to the core (no bypass).

Reset
REQ-021 On i_rst=1 asynchronously: FSM to IDLE, o_d_ack=0, o_d_rdata=0, latched request fields=0.
REQ-022 Reset mid-transaction SHALL abandon it with no RAM write issued after reset assertion and no ack.
REQ-023 o_init_done reset value: 0 with QERV_RF_CLEAR_EN defined, 1 without.

Configuration
REQ-024 Macro QERV_RF_CLEAR_EN SHALL compile in a post-reset RAM clear sequencer.
REQ-025 With it: after reset release, a CLEAR state writes 0 to addresses 0..2^aw-1 in ascending order, one word per cycle with i_c_wen=0; the address counter holds on cycles with i_c_wen=1.
REQ-026 With it: debug requests SHALL wait in IDLE until clear completes; o_init_done goes 1 the cycle after address 2^aw-1 is written and stays 1 until reset.
REQ-027 Without it: no clear state or counter exists; FSM leaves reset directly in IDLE.

Verification
REQ-028 Idle core; debug write addr 0x12 data 0xA5 -> o_wen=1 with o_waddr=0x12, o_wdata=0xA5 one cycle after req; o_d_ack next cycle.
REQ-029 Then debug read addr 0x12 -> o_ren=1 at +1, o_d_ack at +3 with o_d_rdata=0xA5.
REQ-030 Debug read while i_c_ren=1 for 10 cycles -> no debug o_ren during those cycles; issue on first i_c_ren=0 cycle; core o_raddr unaffected.
REQ-031 Debug write 0x3C to addr 0x05 with simultaneous core write 0x77 to addr 0x05 for 1 cycle -> core write first, debug write next cycle; final read returns 0x3C.
REQ-032 Assert i_rst during RD_DATA -> o_d_ack never pulses; FSM IDLE; o_d_rdata=0.
REQ-033 With QERV_RF_CLEAR_EN, aw=4: preload RAM with 0xFF, reset -> 16 zero writes, addresses 0..15; o_init_done rises after 16 cycles (plus one per injected i_c_wen=1 cycle).
